// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, character width, data decode and
// the alignment FSM state encoding.
package tmds_pkg;

  localparam int CHAR_W = 10;

  localparam logic [CHAR_W-1:0] CTRL_TOKEN_00 = 10'h354;
  localparam logic [CHAR_W-1:0] CTRL_TOKEN_01 = 10'h0AB;
  localparam logic [CHAR_W-1:0] CTRL_TOKEN_10 = 10'h154;
  localparam logic [CHAR_W-1:0] CTRL_TOKEN_11 = 10'h2AB;

  typedef enum logic [1:0] {SEARCH, SETTLE, LOCKED} align_state_t;

  typedef struct packed {
    logic       is_token;
    logic [1:0] ctrl;
  } token_t;

  function automatic token_t token_lookup(input logic [CHAR_W-1:0] w);
    token_t t;
    t = '0;
    case (w)
      CTRL_TOKEN_00: t = '{is_token: 1'b1, ctrl: 2'b00};
      CTRL_TOKEN_01: t = '{is_token: 1'b1, ctrl: 2'b01};
      CTRL_TOKEN_10: t = '{is_token: 1'b1, ctrl: 2'b10};
      CTRL_TOKEN_11: t = '{is_token: 1'b1, ctrl: 2'b11};
      default:       t = '0;
    endcase
    return t;
  endfunction

  // q[9] undoes the encoder's DC-balance inversion; q[8] selects XOR vs XNOR chaining.
  function automatic logic [7:0] tmds_decode(input logic [CHAR_W-1:0] q);
    logic [7:0] b;
    logic [7:0] d;
    b    = q[9] ? ~q[7:0] : q[7:0];
    d[0] = b[0];
    for (int i = 1; i < 8; i++)
      d[i] = q[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
    return d;
  endfunction

endpackage

// File: rtl/tmds_align_fsm.sv
// Character alignment: counts control tokens, requests bit slips while
// searching, and holds/drops lock based on token activity.
module tmds_align_fsm
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT    = 16,
  parameter int SEARCH_WINDOW = 2048,
  parameter int SLIP_SETTLE   = 4,
  parameter int LOCK_TIMEOUT  = 4096
) (
  input  logic       pixelClk,
  input  logic       reset,
  input  logic       token,
  output logic       bitslip,
  output logic       locked,
  output logic [3:0] slipCount
);

  localparam int RUN_W  = $clog2(LOCK_COUNT) + 1;
  localparam int WIN_W  = $clog2(SEARCH_WINDOW) + 1;
  localparam int IDLE_W = $clog2(LOCK_TIMEOUT) + 1;
  localparam int SET_W  = $clog2(SLIP_SETTLE) + 1;

  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(LOCK_COUNT);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(LOCK_TIMEOUT - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SLIP_SETTLE - 1);

  align_state_t      state;
  logic [RUN_W-1:0]  tokenRun;
  logic [WIN_W-1:0]  windowCnt;
  logic [IDLE_W-1:0] idleCnt;
  logic [SET_W-1:0]  settleCnt;

  always_ff @(posedge pixelClk) begin
    if (reset) begin
      state     <= SEARCH;
      tokenRun  <= '0;
      windowCnt <= '0;
      idleCnt   <= '0;
      settleCnt <= '0;
      bitslip   <= 1'b0;
      locked    <= 1'b0;
      slipCount <= '0;
    end else begin
      bitslip <= 1'b0;
      case (state)
        SEARCH: begin
          // Lock is checked first so a coincident window expiry never slips.
          if (token && tokenRun == RUN_LAST) begin
            state     <= LOCKED;
            locked    <= 1'b1;
            tokenRun  <= RUN_MAX;
            windowCnt <= '0;
            idleCnt   <= '0;
          end else if (windowCnt == WIN_LAST) begin
            state     <= SETTLE;
            bitslip   <= 1'b1;
            slipCount <= (slipCount == 4'd9) ? 4'd0 : slipCount + 4'd1;
            tokenRun  <= '0;
            windowCnt <= '0;
            settleCnt <= '0;
          end else begin
            windowCnt <= windowCnt + 1'b1;
            if (!token)                tokenRun <= '0;
            else if (tokenRun != RUN_MAX) tokenRun <= tokenRun + 1'b1;
          end
        end
        SETTLE: begin
          tokenRun  <= '0;
          windowCnt <= '0;
          if (settleCnt == SET_LAST) state <= SEARCH;
          else                       settleCnt <= settleCnt + 1'b1;
        end
        LOCKED: begin
          if (token) begin
            idleCnt <= '0;
          end else if (idleCnt == IDLE_LAST) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            idleCnt   <= '0;
            tokenRun  <= '0;
            windowCnt <= '0;
          end else begin
            idleCnt <= idleCnt + 1'b1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: two-stage decode pipeline plus alignment FSM.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT    = 16,
  parameter int SEARCH_WINDOW = 2048,
  parameter int SLIP_SETTLE   = 4,
  parameter int LOCK_TIMEOUT  = 4096
) (
  input  logic              pixelClk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] rawCharacter,
  output logic              bitslip,
  output logic              locked,
  output logic [7:0]        pixelComponent,
  output logic [1:0]        controlBits,
  output logic              dataEnable,
  output logic              outValid,
  output logic [3:0]        slipCount
);

  token_t            tk;
  logic [CHAR_W-1:0] s1_raw;
  logic              s1_tok;
  logic [1:0]        s1_ctrl;
  logic [2:1]        vld_pipe;

  assign tk = token_lookup(rawCharacter);

  always_ff @(posedge pixelClk) begin
    if (reset) begin
      s1_raw         <= '0;
      s1_tok         <= 1'b0;
      s1_ctrl        <= '0;
      pixelComponent <= '0;
      controlBits    <= '0;
      dataEnable     <= 1'b0;
      vld_pipe       <= '0;
    end else begin
      s1_raw   <= rawCharacter;
      s1_tok   <= tk.is_token;
      s1_ctrl  <= tk.ctrl;
      vld_pipe <= {vld_pipe[1], locked};
      // Each field holds its last value while the other kind of period is active.
      if (s1_tok) begin
        dataEnable  <= 1'b0;
        controlBits <= s1_ctrl;
      end else begin
        dataEnable     <= 1'b1;
        pixelComponent <= tmds_decode(s1_raw);
      end
    end
  end

  // Gating with the live lock flag drops outValid in the same cycle lock is lost.
  assign outValid = vld_pipe[2] & locked;

  tmds_align_fsm #(
    .LOCK_COUNT   (LOCK_COUNT),
    .SEARCH_WINDOW(SEARCH_WINDOW),
    .SLIP_SETTLE  (SLIP_SETTLE),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) u_fsm (
    .pixelClk (pixelClk),
    .reset    (reset),
    .token    (s1_tok),
    .bitslip  (bitslip),
    .locked   (locked),
    .slipCount(slipCount)
  );

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: decode table plus lock, slip,
// timeout and reset sequences against a rotating-deserializer model.
module tb_tmds_channel_decoder;
  import tmds_pkg::*;

  logic       pixelClk = 1'b0;
  logic       reset;
  logic [9:0] rawCharacter;
  logic       bitslip, locked, dataEnable, outValid;
  logic [7:0] pixelComponent;
  logic [1:0] controlBits;
  logic [3:0] slipCount;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 pixelClk = ~pixelClk;

  tmds_channel_decoder dut (
    .pixelClk      (pixelClk),
    .reset         (reset),
    .rawCharacter  (rawCharacter),
    .bitslip       (bitslip),
    .locked        (locked),
    .pixelComponent(pixelComponent),
    .controlBits   (controlBits),
    .dataEnable    (dataEnable),
    .outValid      (outValid),
    .slipCount     (slipCount)
  );

  typedef struct {
    logic [9:0] raw;
    logic [7:0] pix;
    logic       de;
    logic [1:0] ctrl;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge pixelClk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] rotr(input logic [9:0] w, input int r);
    logic [19:0] t;
    t = {w, w} >> r;
    return t[9:0];
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bitslip"},  bitslip, 0);
    chk({tag, "_locked"},   locked, 0);
    chk({tag, "_pix"},      pixelComponent, 0);
    chk({tag, "_ctrl"},     controlBits, 0);
    chk({tag, "_de"},       dataEnable, 0);
    chk({tag, "_ovalid"},   outValid, 0);
    chk({tag, "_slipcnt"},  slipCount, 0);
    chk({tag, "_state"},    32'(dut.u_fsm.state), 32'(SEARCH));
  endtask

  initial begin
    // Hand-decoded vectors; token rows expect the previous pixel value held.
    vecs[0] = '{10'h1F8, 8'h08, 1'b1, 2'b00};
    vecs[1] = '{10'h2FF, 8'hFE, 1'b1, 2'b00};
    vecs[2] = '{10'h0AB, 8'hFE, 1'b0, 2'b01};
    vecs[3] = '{10'h100, 8'h00, 1'b1, 2'b00};
    vecs[4] = '{10'h3AA, 8'hFF, 1'b1, 2'b00};
    vecs[5] = '{10'h154, 8'hFF, 1'b0, 2'b10};
    vecs[6] = '{10'h1FF, 8'h01, 1'b1, 2'b00};
    vecs[7] = '{10'h2AB, 8'h01, 1'b0, 2'b11};
    vecs[8] = '{10'h000, 8'hFE, 1'b1, 2'b00};
    vecs[9] = '{10'h055, 8'h01, 1'b1, 2'b00};

    reset = 1'b1;
    rawCharacter = 10'h000;
    tick();
    tick();
    chk_all_zero("reset");

    // Aligned token stream: lock after the 16th token, outValid two cycles later.
    reset = 1'b0;
    rawCharacter = CTRL_TOKEN_00;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 16) chk("lock_early", locked, 0);
      if (c == 17) chk("lock_rise", locked, 1);
      if (c == 18) chk("ovalid_early", outValid, 0);
      if (c == 19) begin
        chk("ovalid_rise", outValid, 1);
        chk("lock_ctrl", controlBits, 2'b00);
        chk("lock_de", dataEnable, 0);
      end
    end

    // Decode table while locked; each vector is followed by a 0x354 token.
    for (int i = 0; i < 10; i++) begin
      rawCharacter = vecs[i].raw;
      tick();
      if (vecs[i].de) chk("latency_gt1", dataEnable, 0);
      rawCharacter = CTRL_TOKEN_00;
      tick();
      chk($sformatf("vec%0d_pix", i), pixelComponent, vecs[i].pix);
      chk($sformatf("vec%0d_de", i), dataEnable, vecs[i].de);
      chk($sformatf("vec%0d_ctrl", i), controlBits, vecs[i].ctrl);
      chk($sformatf("vec%0d_ovalid", i), outValid, 1);
      tick();
      chk($sformatf("vec%0d_hold_pix", i), pixelComponent, vecs[i].pix);
      chk($sformatf("vec%0d_hold_de", i), dataEnable, 0);
    end

    // Withhold tokens: lock drops after LOCK_TIMEOUT non-token cycles.
    begin
      int at = 0;
      logic any_slip = 1'b0;
      rawCharacter = 10'h1F8;
      for (int c = 1; c <= 5000 && at == 0; c++) begin
        tick();
        if (!locked) at = c;
      end
      chk("timeout_cycle", at, 4097);
      chk("timeout_ovalid", outValid, 0);
      chk("timeout_slipcnt", slipCount, 0);
      chk("timeout_state", 32'(dut.u_fsm.state), 32'(SEARCH));
      for (int c = 0; c < 10; c++) begin
        tick();
        any_slip |= bitslip;
      end
      chk("timeout_no_slip", any_slip, 0);
    end

    // 15 tokens, one data word, 16 tokens: only the second run locks.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      rawCharacter = (c == 16) ? 10'h1F8 : CTRL_TOKEN_00;
      tick();
      if (c == 17) chk("run15_no_lock", locked, 0);
      if (c == 32) chk("run2_lock_early", locked, 0);
      if (c == 33) chk("run2_lock", locked, 1);
    end

    // Misaligned by 3: model deserializer rotates one bit per slip pulse.
    begin
      int rot = 3;
      int nslip = 0;
      int last = 0;
      int lock_at = 0;
      reset = 1'b1;
      rawCharacter = rotr(CTRL_TOKEN_00, rot);
      tick();
      reset = 1'b0;
      for (int c = 1; c <= 20000 && lock_at == 0; c++) begin
        rawCharacter = rotr(CTRL_TOKEN_00, rot);
        tick();
        if (bitslip) begin
          nslip++;
          chk($sformatf("slip%0d_period", nslip), c - last, (nslip == 1) ? 2048 : 2052);
          last = c;
          rot = (rot + 1) % 10;
        end
        if (locked) lock_at = c;
      end
      chk("slip_count_pulses", nslip, 7);
      chk("slip_lock_cycle", lock_at, 14380);
      chk("slip_slipcnt", slipCount, 7);
    end

    // Reset while locked returns everything to the idle state in one edge.
    for (int c = 0; c < 5; c++) tick();
    chk("prereset_locked", locked, 1);
    reset = 1'b1;
    tick();
    chk_all_zero("midreset");
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
